button_debounce: RTL and testbench
==================================

Name: button_debounce

Overview:
- Multi-channel push-button front end. Each channel has an N-stage synchroniser, a per-channel debounce counter, and one-cycle press/release strobes.
- Sits between the board button pins and the game FSMs.
- Game logic consumes clean levels and single-cycle edge pulses instead of raw synchronised signals.

Parameters:
- NUM_BTN, 4, number of independent button channels (>=1).
- SYNC_STAGES, 3, synchroniser flip-flop depth per channel (>=2).
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles needed to accept a new level (>=1; 10 ms at 100 MHz).
- REPEAT_DELAY, 50000000, cycles from accepted press to first repeat pulse. Used only with the optional feature.
- REPEAT_PERIOD, 10000000, cycles between subsequent repeat pulses. Used only with the optional feature.
- Derived localparam CNT_W = $clog2(DEBOUNCE_CYCLES+1). Not overridable.

Ports:
- clk, input, 1, system clock; all logic on its rising edge.
- rst, input, 1, synchronous active-high reset.
- btn_in, input, NUM_BTN, raw asynchronous button pins; bit i is channel i; active-high.
- btn_level, output, NUM_BTN, debounced stable level per channel.
- btn_press, output, NUM_BTN, one-cycle pulse when btn_level bit goes 0->1.
- btn_release, output, NUM_BTN, one-cycle pulse when btn_level bit goes 1->0.
- btn_repeat, output, NUM_BTN, auto-repeat pulse. Constant 0 without the optional feature.

Behaviour:
- Clocking and reset:
  - One clock; reset is synchronous and active-high.
  - While rst=1 at a rising edge, every register clears to 0: synchroniser chains, counters, btn_level, btn_press, btn_release, btn_repeat.
  - All outputs are registered.
- Synchroniser: btn_in[i] passes through SYNC_STAGES flip-flops. The last stage is sync[i]. No logic sits between stages.
- Per-channel debounce:
  - If sync[i] == btn_level[i]: cnt[i] <= 0.
  - If sync[i] != btn_level[i] and cnt[i] < DEBOUNCE_CYCLES-1: cnt[i] <= cnt[i]+1.
  - If sync[i] != btn_level[i] and cnt[i] == DEBOUNCE_CYCLES-1: btn_level[i] <= sync[i] and cnt[i] <= 0. On the same edge, btn_press[i] <= sync[i] and btn_release[i] <= ~sync[i].
  - Otherwise btn_press[i] and btn_release[i] are 0 next cycle; strobes are exactly one cycle wide.
  - Any single cycle of agreement (bounce) restarts the count from 0.
- Latency: a clean input step sampled at edge t gives a btn_level change and a coincident strobe visible after edge t + SYNC_STAGES + DEBOUNCE_CYCLES - 1.
- DEBOUNCE_CYCLES = 1: btn_level follows sync with one register delay.
- Channels are fully independent. Simultaneous events on different channels all produce their own strobes in the same cycle.
- Input held high through reset: after rst drops, a press strobe is emitted once the debounce completes. There is no suppression.
- Reset mid-count: partial counts are discarded and no strobe is produced.
- Counter width CNT_W; the counter never exceeds DEBOUNCE_CYCLES-1 and never wraps.

Optional Feature:
- Macro: BUTTON_DEBOUNCE_REPEAT_EN.
- Defined: each channel gets an rpt_cnt (width $clog2 of max(REPEAT_DELAY, REPEAT_PERIOD)+1).
  - rpt_cnt is cleared on the press strobe, then counts while btn_level[i]=1.
  - btn_repeat[i] pulses for one cycle when the count reaches REPEAT_DELAY after the press. It then pulses every REPEAT_PERIOD cycles while held.
  - Release or rst clears rpt_cnt and stops further pulses.
  - btn_repeat never coincides with btn_press.
- Undefined: no repeat logic is synthesised; btn_repeat is tied to 0; port list is unchanged.

Decomposition:
- Shared package game_io_pkg holds:
  - default constants CLK_HZ and DEBOUNCE_MS;
  - a function computing cycles from milliseconds;
  - typedef btn_vec_t sized by the package NUM_BTN default.
- One natural sub-module, debounce_channel: a single channel covering sync chain, counter, strobes and optional repeat. button_debounce instantiates it NUM_BTN times via generate.

Test Plan:
- All tests use NUM_BTN=2, SYNC_STAGES=2, DEBOUNCE_CYCLES=4.
- Reset: hold rst 3 cycles with btn_in=2'b11 -> all outputs 0 during reset. After release, btn_level=2'b11 and btn_press=2'b11 for one cycle, 5 edges after the first non-reset edge.
- Clean press ch0: btn_in[0] 0->1 sampled at edge t -> btn_level[0]=1 and btn_press[0]=1 after edge t+5. btn_press[0]=0 at t+6. Channel 1 outputs stay 0 throughout.
- Bounce: btn_in[0] toggles every 2 cycles for 20 cycles, then is held 1 -> no level change or strobe during the bounce. Exactly one btn_press[0] pulse after the final stable step.
- Release and simultaneous: with ch0=1 and ch1=0, switch btn_in 2'b01->2'b10 on one edge -> after 5 edges, btn_release[0]=1 and btn_press[1]=1 in the same cycle; btn_level=2'b10.
- Reset mid-count: step btn_in[1] to 1 and assert rst when cnt reaches 2 -> no strobe, cnt=0. The level is accepted only after a full new debounce following reset.
- With BUTTON_DEBOUNCE_REPEAT_EN, REPEAT_DELAY=8, REPEAT_PERIOD=3: hold ch0 for 20 cycles after press -> btn_repeat[0] pulses at press+8, +11, +14, +17, +20. Release -> no further pulses.

Source files
------------

// File: rtl/game_io_pkg.sv
// rtl/game_io_pkg.sv - shared button front-end constants, types and cycle helper
package game_io_pkg;

    localparam int CLK_HZ          = 100_000_000;
    localparam int DEBOUNCE_MS     = 10;
    localparam int NUM_BTN_DEFAULT = 4;

    typedef logic [NUM_BTN_DEFAULT-1:0] btn_vec_t;

    function automatic int ms_to_cycles(input int clk_hz, input int ms);
        return (clk_hz / 1000) * ms;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - one button channel: sync chain, debounce counter, strobes
// Auto-repeat logic is built only when BUTTON_DEBOUNCE_REPEAT_EN is defined.
module debounce_channel #(
    parameter int SYNC_STAGES     = 3,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic level,
    output logic press_pulse,
    output logic release_pulse,
    output logic repeat_pulse
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt;
    logic                   sync_bit;
    logic                   accept;

    assign sync_bit = sync_q[SYNC_STAGES-1];
    // Disagreement has persisted for the full window on this edge.
    assign accept   = (sync_bit != level) && (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q        <= '0;
            cnt           <= '0;
            level         <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            sync_q        <= {sync_q[SYNC_STAGES-2:0], btn_raw};
            press_pulse   <= accept & sync_bit;
            release_pulse <= accept & ~sync_bit;
            if (sync_bit == level) begin
                cnt <= '0;
            end else if (accept) begin
                cnt   <= '0;
                level <= sync_bit;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

`ifdef BUTTON_DEBOUNCE_REPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);
    localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

    logic [RPT_W-1:0] rpt_cnt;
    logic             rpt_armed;
    logic             rpt_hit;

    // Before the first repeat the window is the initial delay, afterwards the period.
    assign rpt_hit = rpt_armed ? (rpt_cnt == PERIOD_LAST) : (rpt_cnt == DELAY_LAST);

    always_ff @(posedge clk) begin
        if (rst || !level || accept) begin
            rpt_cnt      <= '0;
            rpt_armed    <= 1'b0;
            repeat_pulse <= 1'b0;
        end else begin
            repeat_pulse <= rpt_hit;
            if (rpt_hit) begin
                rpt_cnt   <= '0;
                rpt_armed <= 1'b1;
            end else begin
                rpt_cnt <= rpt_cnt + 1'b1;
            end
        end
    end
`else
    // Tied low; the repeat parameters stay referenced so both builds share one interface.
    assign repeat_pulse = (REPEAT_DELAY < 0) && (REPEAT_PERIOD < 0);
`endif

endmodule

// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - multi-channel push-button debouncer with press/release strobes
// Optional auto-repeat via BUTTON_DEBOUNCE_REPEAT_EN.
module button_debounce
    import game_io_pkg::*;
#(
    parameter int NUM_BTN         = NUM_BTN_DEFAULT,
    parameter int SYNC_STAGES     = 3,
    parameter int DEBOUNCE_CYCLES = ms_to_cycles(CLK_HZ, DEBOUNCE_MS),
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] btn_in,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release,
    output logic [NUM_BTN-1:0] btn_repeat
);

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
        debounce_channel #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_ch (
            .clk           (clk),
            .rst           (rst),
            .btn_raw       (btn_in[i]),
            .level         (btn_level[i]),
            .press_pulse   (btn_press[i]),
            .release_pulse (btn_release[i]),
            .repeat_pulse  (btn_repeat[i])
        );
    end

endmodule

// File: tb/tb_button_debounce.sv
// tb/tb_button_debounce.sv - scoreboard bench for button_debounce (NUM_BTN=2, SYNC=2, DEBOUNCE=4)
module tb_button_debounce;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] btn_in = 2'b11;
    logic [1:0] btn_level;
    logic [1:0] btn_press;
    logic [1:0] btn_release;
    logic [1:0] btn_repeat;

    typedef struct {
        int       cyc;
        logic [1:0] press;
        logic [1:0] rel;
        logic [1:0] level;
    } ev_t;

    ev_t exp_q[$];
    int  checks   = 0;
    int  failures = 0;
    int  cyc      = 0;

    button_debounce #(
        .NUM_BTN         (2),
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (8),
        .REPEAT_PERIOD   (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_in      (btn_in),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .btn_repeat  (btn_repeat)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Stimulus changes at a negedge (cyc == e) are sampled at edge e+1 and
    // produce the strobe at edge e+6 with two sync stages and a 4-cycle window.
    task automatic test_reset();
        ev_t e;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({btn_level, btn_press, btn_release, btn_repeat} !== 8'h00) begin
                failures++;
                $display("FAIL reset_outputs cyc=%0d got level=%b press=%b release=%b repeat=%b want all 0",
                         cyc, btn_level, btn_press, btn_release, btn_repeat);
            end
        end
        rst = 1'b0;
        exp_q.push_back('{cyc + 6, 2'b11, 2'b00, 2'b11});
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if ((btn_press | btn_release) !== 2'b00) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL reset_extra_strobe cyc=%0d press=%b release=%b want none", cyc, btn_press, btn_release);
                end else begin
                    e = exp_q.pop_front();
                    if (cyc !== e.cyc || btn_press !== e.press || btn_release !== e.rel || btn_level !== e.level) begin
                        failures++;
                        $display("FAIL reset_strobe got cyc=%0d p=%b r=%b l=%b want cyc=%0d p=%b r=%b l=%b",
                                 cyc, btn_press, btn_release, btn_level, e.cyc, e.press, e.rel, e.level);
                    end
                end
            end
        end
        checks++;
        if (exp_q.size() != 0 || btn_level !== 2'b11) begin
            failures++;
            $display("FAIL reset_final pending=%0d level=%b want pending=0 level=11", exp_q.size(), btn_level);
        end
        exp_q.delete();
    endtask

    task automatic test_release_all(input logic [1:0] rel_mask, input string name);
        ev_t e;
        logic [1:0] lvl_after;
        lvl_after = btn_level & ~rel_mask;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if ((btn_press | btn_release) !== 2'b00) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL %s_extra_strobe cyc=%0d press=%b release=%b want none", name, cyc, btn_press, btn_release);
                end else begin
                    e = exp_q.pop_front();
                    if (cyc !== e.cyc || btn_press !== e.press || btn_release !== e.rel || btn_level !== e.level) begin
                        failures++;
                        $display("FAIL %s_strobe got cyc=%0d p=%b r=%b l=%b want cyc=%0d p=%b r=%b l=%b",
                                 name, cyc, btn_press, btn_release, btn_level, e.cyc, e.press, e.rel, e.level);
                    end
                end
            end
            if (i == 0) begin
                btn_in = lvl_after;
                exp_q.push_back('{cyc + 6, 2'b00, rel_mask, lvl_after});
            end
        end
        checks++;
        if (exp_q.size() != 0 || btn_level !== lvl_after) begin
            failures++;
            $display("FAIL %s_final pending=%0d level=%b want pending=0 level=%b", name, exp_q.size(), btn_level, lvl_after);
        end
        exp_q.delete();
    endtask

    task automatic test_clean_press();
        ev_t e;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            checks++;
            if (btn_level[1] !== 1'b0 || btn_press[1] !== 1'b0 || btn_release[1] !== 1'b0) begin
                failures++;
                $display("FAIL clean_ch1_quiet cyc=%0d got level=%b press=%b release=%b want ch1 0",
                         cyc, btn_level, btn_press, btn_release);
            end
`ifndef BUTTON_DEBOUNCE_REPEAT_EN
            checks++;
            if (btn_repeat !== 2'b00) begin
                failures++;
                $display("FAIL clean_repeat_tied cyc=%0d got %b want 00", cyc, btn_repeat);
            end
`endif
            if ((btn_press | btn_release) !== 2'b00) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL clean_extra_strobe cyc=%0d press=%b release=%b want none", cyc, btn_press, btn_release);
                end else begin
                    e = exp_q.pop_front();
                    if (cyc !== e.cyc || btn_press !== e.press || btn_release !== e.rel || btn_level !== e.level) begin
                        failures++;
                        $display("FAIL clean_strobe got cyc=%0d p=%b r=%b l=%b want cyc=%0d p=%b r=%b l=%b",
                                 cyc, btn_press, btn_release, btn_level, e.cyc, e.press, e.rel, e.level);
                    end
                end
            end
            if (i == 0) begin
                btn_in = 2'b01;
                exp_q.push_back('{cyc + 6, 2'b01, 2'b00, 2'b01});
            end
        end
        checks++;
        if (exp_q.size() != 0 || btn_level !== 2'b01) begin
            failures++;
            $display("FAIL clean_final pending=%0d level=%b want pending=0 level=01", exp_q.size(), btn_level);
        end
        exp_q.delete();
    endtask

    task automatic test_bounce();
        ev_t e;
        for (int i = 0; i < 34; i++) begin
            @(negedge clk);
            if ((btn_press | btn_release) !== 2'b00) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL bounce_extra_strobe cyc=%0d press=%b release=%b want none", cyc, btn_press, btn_release);
                end else begin
                    e = exp_q.pop_front();
                    if (cyc !== e.cyc || btn_press !== e.press || btn_release !== e.rel || btn_level !== e.level) begin
                        failures++;
                        $display("FAIL bounce_strobe got cyc=%0d p=%b r=%b l=%b want cyc=%0d p=%b r=%b l=%b",
                                 cyc, btn_press, btn_release, btn_level, e.cyc, e.press, e.rel, e.level);
                    end
                end
            end
            if (i < 20) begin
                checks++;
                if (i > 0 && btn_level !== 2'b00) begin
                    failures++;
                    $display("FAIL bounce_level_stable cyc=%0d got %b want 00", cyc, btn_level);
                end
                btn_in = {1'b0, ((i / 2) % 2) == 0};
            end else if (i == 20) begin
                btn_in = 2'b01;
                exp_q.push_back('{cyc + 6, 2'b01, 2'b00, 2'b01});
            end
        end
        checks++;
        if (exp_q.size() != 0 || btn_level !== 2'b01) begin
            failures++;
            $display("FAIL bounce_final pending=%0d level=%b want pending=0 level=01", exp_q.size(), btn_level);
        end
        exp_q.delete();
    endtask

    task automatic test_simultaneous();
        ev_t e;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if ((btn_press | btn_release) !== 2'b00) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL simul_extra_strobe cyc=%0d press=%b release=%b want none", cyc, btn_press, btn_release);
                end else begin
                    e = exp_q.pop_front();
                    if (cyc !== e.cyc || btn_press !== e.press || btn_release !== e.rel || btn_level !== e.level) begin
                        failures++;
                        $display("FAIL simul_strobe got cyc=%0d p=%b r=%b l=%b want cyc=%0d p=%b r=%b l=%b",
                                 cyc, btn_press, btn_release, btn_level, e.cyc, e.press, e.rel, e.level);
                    end
                end
            end
            if (i == 0) begin
                btn_in = 2'b10;
                exp_q.push_back('{cyc + 6, 2'b10, 2'b01, 2'b10});
            end
        end
        checks++;
        if (exp_q.size() != 0 || btn_level !== 2'b10) begin
            failures++;
            $display("FAIL simul_final pending=%0d level=%b want pending=0 level=10", exp_q.size(), btn_level);
        end
        exp_q.delete();
    endtask

    task automatic test_reset_mid_count();
        ev_t e;
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            if ((btn_press | btn_release) !== 2'b00) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL midrst_extra_strobe cyc=%0d press=%b release=%b want none", cyc, btn_press, btn_release);
                end else begin
                    e = exp_q.pop_front();
                    if (cyc !== e.cyc || btn_press !== e.press || btn_release !== e.rel || btn_level !== e.level) begin
                        failures++;
                        $display("FAIL midrst_strobe got cyc=%0d p=%b r=%b l=%b want cyc=%0d p=%b r=%b l=%b",
                                 cyc, btn_press, btn_release, btn_level, e.cyc, e.press, e.rel, e.level);
                    end
                end
            end
            if (i > 0 && i <= 11) begin
                checks++;
                if (btn_level !== 2'b00) begin
                    failures++;
                    $display("FAIL midrst_level_held cyc=%0d got %b want 00", cyc, btn_level);
                end
            end
            if (i == 0) btn_in = 2'b10;
            if (i == 4) rst = 1'b1;
            if (i == 6) begin
                rst = 1'b0;
                exp_q.push_back('{cyc + 6, 2'b10, 2'b00, 2'b10});
            end
        end
        checks++;
        if (exp_q.size() != 0 || btn_level !== 2'b10) begin
            failures++;
            $display("FAIL midrst_final pending=%0d level=%b want pending=0 level=10", exp_q.size(), btn_level);
        end
        exp_q.delete();
    endtask

`ifdef BUTTON_DEBOUNCE_REPEAT_EN
    task automatic test_repeat();
        ev_t e;
        int  p;
        int  d;
        logic exp_rpt;
        p = -100;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            d = cyc - p;
            exp_rpt = (d >= 8) && (d < 22) && (((d - 8) % 3) == 0);
            checks++;
            if (btn_repeat[0] !== exp_rpt) begin
                failures++;
                $display("FAIL repeat_ch0 cyc=%0d press+%0d got %b want %b", cyc, d, btn_repeat[0], exp_rpt);
            end
            if ((btn_press | btn_release) !== 2'b00) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL repeat_extra_strobe cyc=%0d press=%b release=%b want none", cyc, btn_press, btn_release);
                end else begin
                    e = exp_q.pop_front();
                    if (cyc !== e.cyc || btn_press !== e.press || btn_release !== e.rel || btn_level !== e.level) begin
                        failures++;
                        $display("FAIL repeat_strobe got cyc=%0d p=%b r=%b l=%b want cyc=%0d p=%b r=%b l=%b",
                                 cyc, btn_press, btn_release, btn_level, e.cyc, e.press, e.rel, e.level);
                    end
                end
            end
            if (i == 0) begin
                btn_in = 2'b11;
                p = cyc + 6;
                exp_q.push_back('{p, 2'b01, 2'b00, 2'b11});
            end else if (cyc == p + 16) begin
                btn_in = 2'b10;
                exp_q.push_back('{p + 22, 2'b00, 2'b01, 2'b10});
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL repeat_final pending=%0d want 0", exp_q.size());
        end
        exp_q.delete();
    endtask
`endif

    initial begin
        test_reset();
        test_release_all(2'b11, "release_both");
        test_clean_press();
        test_release_all(2'b01, "release_ch0");
        test_bounce();
        test_simultaneous();
        test_release_all(2'b10, "release_ch1");
        test_reset_mid_count();
`ifdef BUTTON_DEBOUNCE_REPEAT_EN
        test_repeat();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
